// File: rtl/mux_arb_pkg.sv
// Shared constants and state type for the round-robin mux arbiter.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: scans last+1 .. last+4 (mod 4), so the previous owner ranks lowest.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   win,
    output logic               any
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            // index arithmetic wraps naturally in SEL_W bits
            idx = last + SEL_W'(i);
            if (!any && req[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready output channel between four sources, with bounded bursts.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int HOLD  = 4
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    input  logic [WIDTH-1:0]     d,
    input  logic                 o_ready,
    output logic [SEL_W-1:0]     s,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [WIDTH-1:0]     o,
    output logic                 o_valid,
    output logic                 busy
);

    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD - 1);

    arb_state_t       state;
    logic [SEL_W-1:0] last;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] pick_last;
    logic [SEL_W-1:0] win;
    logic             any;
    logic             accepted;
    logic             rel;

    assign busy     = (state == GRANT);
    assign o_valid  = busy & req[s];
    assign accepted = o_valid & o_ready;
    assign rel      = busy & ((accepted & (cnt == '0)) | ~req[s]);

    // On release the outgoing owner becomes "last" in the same cycle, so the picker sees it early.
    assign pick_last = rel ? s : last;

    rr_pick u_pick (
        .req  (req),
        .last (pick_last),
        .win  (win),
        .any  (any)
    );

    always_comb begin
        o = '0;
        if (o_valid) begin
            case (s)
                2'd0:    o = a;
                2'd1:    o = b;
                2'd2:    o = c;
                default: o = d;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            s     <= '0;
            gnt   <= '0;
            last  <= 2'd3;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        s     <= win;
                        gnt   <= NUM_REQ'(1) << win;
                        cnt   <= CNT_LOAD;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        last <= s;
                        if (any) begin
                            s   <= win;
                            gnt <= NUM_REQ'(1) << win;
                            cnt <= CNT_LOAD;
                        end else begin
                            gnt   <= '0;
                            state <= IDLE;
                        end
                    end else if (accepted) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: owner/beat-count model checked every cycle plus literal expectations.
module tb_mux_rr_arbiter;

    localparam int WIDTH = 2;
    localparam int HOLD  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req;
    logic [WIDTH-1:0] a, b, c, d;
    logic             o_ready;
    logic [1:0]       s;
    logic [3:0]       gnt;
    logic [WIDTH-1:0] o;
    logic             o_valid;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    // model: who owns the channel and how many accepted beats remain in its burst
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_last  = 3;
    int m_left  = HOLD;

    mux_rr_arbiter #(.WIDTH(WIDTH), .HOLD(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .o_ready (o_ready),
        .s       (s),
        .gnt     (gnt),
        .o       (o),
        .o_valid (o_valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic int pick(logic [3:0] r, int lst);
        for (int k = 1; k <= 4; k++) begin
            int j;
            j = (lst + k) % 4;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] src_data(int idx);
        case (idx)
            0:       return a;
            1:       return b;
            2:       return c;
            default: return d;
        endcase
    endfunction

    task automatic chk(string name, int unsigned act, int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    always @(posedge clk) begin
        bit nb;
        int no, nl, nleft, w;
        nb = m_busy; no = m_owner; nl = m_last; nleft = m_left;
        if (rst) begin
            nb = 1'b0; no = 0; nl = 3; nleft = HOLD;
        end else if (!nb) begin
            w = pick(req, nl);
            if (w >= 0) begin
                nb = 1'b1; no = w; nleft = HOLD;
            end
        end else begin
            if (req[no] && o_ready) nleft = nleft - 1;
            if (!req[no] || nleft == 0) begin
                nl = no;
                w = pick(req, nl);
                if (w >= 0) begin
                    no = w; nleft = HOLD;
                end else begin
                    nb = 1'b0;
                end
            end
        end
        m_busy  <= nb;
        m_owner <= no;
        m_last  <= nl;
        m_left  <= nleft;
    end

    always @(negedge clk) begin
        bit exp_valid;
        exp_valid = m_busy && req[m_owner];
        chk("model_busy",  busy, m_busy);
        chk("model_valid", o_valid, exp_valid);
        chk("model_gnt",   gnt, m_busy ? (4'b0001 << m_owner) : 4'b0000);
        chk("model_o",     o, exp_valid ? src_data(m_owner) : '0);
        if (m_busy) chk("model_s", s, m_owner);
    end

    // apply inputs just after a rising edge, return at the following falling edge
    task automatic drive(logic r, logic [3:0] rq, logic rdy);
        @(posedge clk);
        #1;
        rst = r; req = rq; o_ready = rdy;
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] contention_data [4];
        logic       bp_ready [7];

        rst = 1'b1; req = '0; o_ready = 1'b1;
        a = '0; b = '0; c = '0; d = '0;

        // reset state
        drive(1, 4'b0000, 1);
        drive(1, 4'b0000, 1);
        chk("rst_gnt", gnt, 0);
        chk("rst_s", s, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_o", o, 0);

        // single requester a
        a = 2'b01;
        drive(0, 4'b0001, 1);
        chk("single_idle_valid", o_valid, 0);
        drive(0, 4'b0001, 1);
        chk("single_gnt", gnt, 4'b0001);
        chk("single_s", s, 0);
        chk("single_o", o, 2'b01);
        for (int i = 0; i < 8; i++) begin
            chk("single_regrant_valid", o_valid, 1);
            chk("single_regrant_gnt", gnt, 4'b0001);
            drive(0, 4'b0001, 1);
        end
        drive(0, 4'b0000, 1);
        chk("single_drop_valid", o_valid, 0);
        chk("single_drop_busy", busy, 1);
        drive(0, 4'b0000, 1);
        chk("single_idle_gnt", gnt, 0);

        // full contention after reset: a, b, c, d, a
        contention_data[0] = 2'b00; contention_data[1] = 2'b01;
        contention_data[2] = 2'b11; contention_data[3] = 2'b00;
        a = contention_data[0]; b = contention_data[1];
        c = contention_data[2]; d = contention_data[3];
        drive(1, 4'b1111, 1);
        drive(0, 4'b1111, 1);
        for (int k = 0; k < 17; k++) begin
            drive(0, 4'b1111, 1);
            chk("contend_gnt", gnt, 4'b0001 << ((k / 4) % 4));
            chk("contend_o", o, contention_data[(k / 4) % 4]);
        end

        // backpressure on owner b: 4 accepted beats over 7 cycles, then d
        bp_ready = '{1, 1, 0, 0, 0, 1, 1};
        a = 2'b00; b = 2'b10; c = 2'b01; d = 2'b11;
        drive(1, 4'b0000, 1);
        drive(0, 4'b0010, 1);
        for (int k = 0; k < 7; k++) begin
            drive(0, 4'b1010, bp_ready[k]);
            chk("bp_s", s, 1);
            chk("bp_valid", o_valid, 1);
            chk("bp_o", o, 2'b10);
        end
        drive(0, 4'b1010, 1);
        chk("bp_handover_gnt", gnt, 4'b1000);

        // early drop by c while d waits
        drive(1, 4'b0000, 1);
        drive(0, 4'b0100, 1);
        drive(0, 4'b1100, 1);
        chk("drop_c_gnt", gnt, 4'b0100);
        chk("drop_c_o", o, 2'b01);
        drive(0, 4'b1000, 1);
        chk("drop_valid", o_valid, 0);
        chk("drop_o", o, 0);
        drive(0, 4'b1000, 1);
        chk("drop_next_gnt", gnt, 4'b1000);
        chk("drop_next_s", s, 3);

        // priority right after reset with b and d requesting
        drive(1, 4'b1010, 1);
        drive(0, 4'b1010, 1);
        chk("prio_idle_busy", busy, 0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 4'b1010, 1);
            chk("prio_first_gnt", gnt, 4'b0010);
        end
        drive(0, 4'b0000, 1);
        chk("prio_second_gnt", gnt, 4'b1000);
        chk("prio_second_valid", o_valid, 0);
        drive(0, 4'b0000, 1);
        chk("prio_idle_gnt", gnt, 0);
        chk("prio_idle_o", o, 0);
        chk("prio_idle_busy2", busy, 0);

        // reset in the middle of a grant to d
        drive(1, 4'b0000, 1);
        drive(0, 4'b1000, 1);
        drive(0, 4'b1000, 1);
        chk("mid_pre_gnt", gnt, 4'b1000);
        drive(1, 4'b1111, 1);
        chk("mid_rst_cycle_gnt", gnt, 4'b1000);
        drive(0, 4'b1111, 1);
        chk("mid_post_gnt", gnt, 0);
        chk("mid_post_s", s, 0);
        chk("mid_post_busy", busy, 0);
        drive(0, 4'b1111, 1);
        chk("mid_first_gnt", gnt, 4'b0001);

        drive(0, 4'b0000, 1);
        drive(0, 4'b0000, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
